// File: rtl/zbuf_pkg.sv
// zbuf_pkg: shared types, defaults and width helper for fill_arbiter.
// Holds the FSM state enum and the default parameter constants.
package zbuf_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_FILL_WIDTH  = 8;
  localparam int DEF_ACK_TIMEOUT = 15;
  localparam int DEF_AGE_LIMIT   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  // Bits needed to index n items (never less than 1).
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fill_select_tree.sv
// fill_select_tree: picks the channel to serve next.
// Ports: fill/age per channel in; any (some channel eligible)
// and sel (winning index) out. Purely combinational.
module fill_select_tree
  import zbuf_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FILL_WIDTH = DEF_FILL_WIDTH,
  parameter int AGE_LIMIT  = DEF_AGE_LIMIT,
  localparam int ID_W      = bits_for(NUM_CH),
  localparam int AGE_W     = bits_for(AGE_LIMIT + 1)
) (
  input  logic [NUM_CH*FILL_WIDTH-1:0] fill,
  input  logic [NUM_CH*AGE_W-1:0]      age,
  output logic                         any,
  output logic [ID_W-1:0]              sel
);

  localparam int LEAVES = 1 << ID_W;

  // Pad to a power of two; padded channels have zero fill
  // and so can never win.
  logic [LEAVES*FILL_WIDTH-1:0] fill_p;
  logic [LEAVES*AGE_W-1:0]      age_p;

  assign fill_p = (LEAVES*FILL_WIDTH)'(fill);
  assign age_p  = (LEAVES*AGE_W)'(age);

  // Per-slot candidate: valid, forced by age, fill, index.
  logic                  vld [LEAVES];
  logic                  frc [LEAVES];
  logic [FILL_WIDTH-1:0] lvl [LEAVES];
  logic [ID_W-1:0]       idx [LEAVES];

  logic take_b;

  // Pairwise reduction: at stride s, slot k absorbs slot k+s.
  // Slot k always covers the lower indices, so ties keep k.
  always_comb begin
    take_b = 1'b0;
    for (int i = 0; i < LEAVES; i++) begin
      lvl[i] = fill_p[i*FILL_WIDTH +: FILL_WIDTH];
      vld[i] = |lvl[i];
      frc[i] = vld[i] &&
               (age_p[i*AGE_W +: AGE_W] >= AGE_W'(AGE_LIMIT));
      idx[i] = ID_W'(i);
    end
    for (int s = 1; s < LEAVES; s = s * 2) begin
      for (int k = 0; k + s < LEAVES; k = k + 2 * s) begin
        if (frc[k] != frc[k+s]) begin
          take_b = frc[k+s];
        end else if (frc[k]) begin
          take_b = 1'b0;
        end else if (vld[k] != vld[k+s]) begin
          take_b = vld[k+s];
        end else begin
          take_b = lvl[k+s] > lvl[k];
        end
        if (take_b) begin
          lvl[k] = lvl[k+s];
          idx[k] = idx[k+s];
        end
        vld[k] = vld[k] | vld[k+s];
        frc[k] = frc[k] | frc[k+s];
      end
    end
    any = vld[0];
    sel = idx[0];
  end

endmodule

// File: rtl/fill_arbiter.sv
// fill_arbiter: drains the fullest source into the z-buffer.
// Ports: fill/pix_in/ack from sources, rdy_z_buffer in; req,
// send_z_buffer, pix_out, grant_id, timeout_err out.
module fill_arbiter
  import zbuf_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int FILL_WIDTH  = DEF_FILL_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int AGE_LIMIT   = DEF_AGE_LIMIT,
  localparam int ID_W       = bits_for(NUM_CH),
  localparam int AGE_W      = bits_for(AGE_LIMIT + 1),
  localparam int TMO_W      = bits_for(ACK_TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*FILL_WIDTH-1:0]  fill,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] pix_in,
  input  logic [NUM_CH-1:0]             ack,
  input  logic                          rdy_z_buffer,
  output logic [NUM_CH-1:0]             req,
  output logic                          send_z_buffer,
  output logic [PIXEL_WIDTH-1:0]        pix_out,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err
);

  state_t state;
  state_t state_nx;

  logic [AGE_W-1:0]        age [NUM_CH];
  logic [NUM_CH*AGE_W-1:0] age_flat;
  logic [NUM_CH-1:0]       elig;
  logic [TMO_W-1:0]        tmo_cnt;

  logic                   any_elig;
  logic [ID_W-1:0]        sel;
  logic [NUM_CH-1:0]      gmask;
  logic [PIXEL_WIDTH-1:0] pix_sel;

  logic decide;
  logic ack_hit;
  logic tmo_hit;

  always_comb begin
    age_flat = '0;
    elig     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      age_flat[i*AGE_W +: AGE_W] = age[i];
      elig[i] = |fill[i*FILL_WIDTH +: FILL_WIDTH];
    end
  end

  fill_select_tree #(
    .NUM_CH     (NUM_CH),
    .FILL_WIDTH (FILL_WIDTH),
    .AGE_LIMIT  (AGE_LIMIT)
  ) u_sel (
    .fill (fill),
    .age  (age_flat),
    .any  (any_elig),
    .sel  (sel)
  );

  // One-hot of the held grant; also steers the pixel mux so
  // ack and pixel of other channels never reach the datapath.
  always_comb begin
    gmask   = '0;
    pix_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gmask[i] = (grant_id == ID_W'(i));
      if (gmask[i]) begin
        pix_sel = pix_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  assign decide  = (state == IDLE) && rdy_z_buffer && any_elig;
  assign ack_hit = |(ack & gmask);
  assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // In REQ an ack beats both a dropped ready and the timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rdy_z_buffer && any_elig) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (ack_hit) begin
          state_nx = SEND;
        end else if (!rdy_z_buffer || tmo_hit) begin
          state_nx = IDLE;
        end
      end
      SEND: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    req           = '0;
    send_z_buffer = 1'b0;
    if (state == REQ) begin
      req = gmask;
    end
    if (state == SEND) begin
      send_z_buffer = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id    <= '0;
      pix_out     <= '0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        age[i] <= '0;
      end
    end else begin
      timeout_err <= 1'b0;
      if (decide) begin
        grant_id <= sel;
        tmo_cnt  <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel == ID_W'(i)) begin
            age[i] <= '0;
          end else if (elig[i] &&
                       age[i] < AGE_W'(AGE_LIMIT)) begin
            age[i] <= age[i] + 1'b1;
          end
        end
      end
      if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (ack_hit) begin
          pix_out <= pix_sel;
        end else if (rdy_z_buffer && tmo_hit) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
